// File: rtl/mips_pkg.sv
// Shared MIPS opcode/funct constants, MD-unit default latencies and the one-hot MD op class.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_MADD  = 6'h00;
  localparam logic [5:0] FN_MADDU = 6'h01;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic mult;
    logic multu;
    logic div;
    logic divu;
    logic madd;
    logic maddu;
    logic mfhi;
    logic mflo;
    logic mthi;
    logic mtlo;
  } md_op_t;

endpackage

// File: rtl/mdu_decode.sv
// Combinational decode of an E-stage instruction into a one-hot MD op class.
// madd/maddu are recognised only when MDU_MADD_EN is defined.
module mdu_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output md_op_t      op
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    op = '0;
    unique case (opcode)
      OP_SPECIAL: begin
        unique case (funct)
          FN_MULT:  op.mult  = 1'b1;
          FN_MULTU: op.multu = 1'b1;
          FN_DIV:   op.div   = 1'b1;
          FN_DIVU:  op.divu  = 1'b1;
          FN_MFHI:  op.mfhi  = 1'b1;
          FN_MFLO:  op.mflo  = 1'b1;
          FN_MTHI:  op.mthi  = 1'b1;
          FN_MTLO:  op.mtlo  = 1'b1;
          default:  ;
        endcase
      end
`ifdef MDU_MADD_EN
      OP_SPECIAL2: begin
        unique case (funct)
          FN_MADD:  op.madd  = 1'b1;
          FN_MADDU: op.maddu = 1'b1;
          default:  ;
        endcase
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_e.sv
// E-stage multiply/divide unit: fixed-latency HI/LO update with a busy interlock.
// Define MDU_MADD_EN to add SPECIAL2 madd/maddu (accumulate into HI:LO).
module mdu_e
  import mips_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_e,
  input  logic [31:0] rs_val_e,
  input  logic [31:0] rt_val_e,
  output logic        start,
  output logic        busy,
  output logic [31:0] md_rd
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  md_op_t op;

  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [63:0]     pend_q, pend_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;

  logic        is_mul, is_div, is_signed;
  logic [63:0] a_ext, b_ext, product, mul_res;
  logic [31:0] quo, rem;
  logic [63:0] div_res;

  mdu_decode u_decode (
    .instr (instr_e),
    .op    (op)
  );

  assign is_mul    = op.mult | op.multu | op.madd | op.maddu;
  assign is_div    = op.div | op.divu;
  assign is_signed = op.mult | op.div | op.madd;

  assign start = (is_mul | is_div) & ~busy_q;
  assign busy  = busy_q;
  assign md_rd = op.mfhi ? hi_q : lo_q;

  // Sign- or zero-extend to 64 bits so one truncated product serves both flavours.
  assign a_ext   = is_signed ? {{32{rs_val_e[31]}}, rs_val_e} : {32'b0, rs_val_e};
  assign b_ext   = is_signed ? {{32{rt_val_e[31]}}, rt_val_e} : {32'b0, rt_val_e};
  assign product = a_ext * b_ext;
  assign mul_res = (op.madd | op.maddu) ? ({hi_q, lo_q} + product) : product;

  always_comb begin
    quo = '0;
    rem = '0;
    if (op.div) begin
      if (rs_val_e == 32'h8000_0000 && rt_val_e == 32'hFFFF_FFFF) begin
        quo = 32'h8000_0000;
        rem = '0;
      end else begin
        quo = $signed(rs_val_e) / $signed(rt_val_e);
        rem = $signed(rs_val_e) % $signed(rt_val_e);
      end
    end else begin
      quo = rs_val_e / rt_val_e;
      rem = rs_val_e % rt_val_e;
    end
  end

  // Divide by zero re-commits the current HI/LO, i.e. leaves them unchanged.
  assign div_res = (rt_val_e == 32'b0) ? {hi_q, lo_q} : {rem, quo};

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      pend_d = is_mul ? mul_res : div_res;
      cnt_d  = is_mul ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
      busy_d = 1'b1;
    end else if (busy_q) begin
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        hi_d   = pend_q[63:32];
        lo_d   = pend_q[31:0];
        busy_d = 1'b0;
      end
    end else begin
      if (op.mthi) hi_d = rs_val_e;
      if (op.mtlo) lo_d = rs_val_e;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: doc/mdu_e.md
MDU_E -- requirements
Module: mdu_e

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- instr_e  in  32  E-stage instruction word; 0 is a bubble.
- rs_val_e  in  32  forwarded rs operand.
- rt_val_e  in  32  forwarded rt operand.
- start  out  1  mult/multu/div/divu accepted this cycle.
- busy  out  1  operation in flight.
- md_rd  out  32  HI for mfhi, LO otherwise.
REQ-002 SHALL use clock clk and reset reset (synchronous, active-high); both are already decided.
REQ-003 SHALL have the parameters:
- MULT_CYCLES, default 5, busy cycles for mult/multu.
- DIV_CYCLES, default 10, busy cycles for div/divu.

Function
REQ-004 SHALL decode SPECIAL (opcode 0) funct codes internally: mult 0x18, multu 0x19, div 0x1A, divu 0x1B, mfhi 0x10, mflo 0x12, mthi 0x11, mtlo 0x13.
REQ-005 start SHALL be combinational: high iff instr_e is mult/multu/div/divu and busy=0.
REQ-006 On the edge with start=1, the block SHALL compute the result into pending registers and set busy=1.
- Pending result: 64-bit product, or {remainder, quotient} as {HI, LO}.
- Counter SHALL load MULT_CYCLES or DIV_CYCLES.
REQ-007 While busy, the counter SHALL decrement each edge.
- On the edge where counter=1, pending HI/LO SHALL commit and busy SHALL clear.
- Net effect: busy is high for exactly N cycles after the start edge.
REQ-008 Signed ops (mult, div) SHALL use two's-complement 32x32 arithmetic; unsigned ops (multu, divu) SHALL zero-extend.
REQ-009 div/divu with rt_val_e=0 SHALL run the full DIV_CYCLES and leave HI/LO unchanged.
REQ-010 Signed div of 0x80000000 by 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-011 mthi/mtlo with busy=0 SHALL write rs_val_e to HI/LO at the next edge.
REQ-012 md_rd SHALL be combinational from committed HI/LO only; it SHALL never show pending values.
REQ-013 Any MD-class instruction (mult/div/mthi/mtlo/mfhi/mflo) presented while busy=1 SHALL have no effect on state.
- Stalling such instructions is the hazard unit's job; it uses start|busy.
REQ-014 Non-MD instructions and bubbles SHALL leave all state unchanged.

Reset
REQ-015 When reset is high at an edge:
- HI=0, LO=0, pending registers=0, counter=0, busy=0.
- This applies mid-operation and discards the in-flight result.
REQ-016 Reset SHALL take priority over start and over commit in the same cycle.
REQ-017 After reset: start=0 unless instr_e decodes as a start op; md_rd=0.

Configuration
REQ-018 Macro MDU_MADD_EN:
- Defined: SPECIAL2 (opcode 0x1C) madd funct 0x00 and maddu funct 0x01 SHALL start as multiplies. They take MULT_CYCLES and commit {HI,LO} + product, mod 2^64.
- Undefined: these encodings SHALL be treated as non-MD instructions (REQ-014).

Structure
REQ-020 Opcode/funct constants and default latencies SHALL live in the shared package mips_pkg.
REQ-021 Decoding SHALL be one combinational sub-module, mdu_decode (instr in; one-hot op class out).
- The counter, pending registers and HI/LO SHALL stay in mdu_e.

Verification
REQ-022 multu, rs=0xFFFFFFFF, rt=2 -> start=1 for one cycle, busy high for 5 cycles, then HI=1, LO=0xFFFFFFFE; mfhi -> md_rd=1.
REQ-023 div, rs=-7, rt=2 -> busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; md_rd stays at old LO until commit.
REQ-024 divu, rt=0, after mtlo 0x1234 -> LO stays 0x1234 after 10 cycles.
REQ-025 mult started, reset asserted on the 3rd busy cycle -> busy=0, HI=LO=0, no later commit.
REQ-026 mthi 0x55 presented during busy -> HI not written; the pending mult result commits normally.
REQ-027 With MDU_MADD_EN, HI:LO=0:0xFFFFFFFF, madd 1*1 -> HI=1, LO=0. Without it -> no start, HI/LO unchanged.
